// File: rtl/mat_dot_product_unit_pkg.sv
// mat_dot_product_unit_pkg: shared widths and FSM encoding for the dot-product engine
// Contents:
//   DP_DATA_W   signed operand width
//   DP_VEC_LEN  elements per dot product
//   DP_CNT_W    element counter width
//   DP_ACC_W    accumulator/result width (sized so it cannot overflow)
//   dp_state_t  ACCUM / FLUSH / HOLD state encoding
package mat_dot_product_unit_pkg;
    localparam int DP_DATA_W  = 16;
    localparam int DP_VEC_LEN = 4;
    localparam int DP_CNT_W   = $clog2(DP_VEC_LEN);
    localparam int DP_ACC_W   = 2 * DP_DATA_W + DP_CNT_W;
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } dp_state_t;
endpackage

// File: rtl/mat_dot_product_unit_mult.sv
// mat_mult_stage: registered signed multiplier with valid/first/last sideband
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              operand pair accepted this cycle
//   first, last     position tags of the accepted pair within its vector
//   a, b            signed operands
//   prod            sign-extended registered product
//   p_valid         prod holds a fresh product this cycle
//   p_first, p_last registered position tags travelling with prod
module mat_mult_stage
    import mat_dot_product_unit_pkg::*;
#(
    parameter int DATA_W = DP_DATA_W,
    parameter int ACC_W  = DP_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     first,
    input  logic                     last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  prod,
    output logic                     p_valid,
    output logic                     p_first,
    output logic                     p_last
);
    logic signed [2*DATA_W-1:0] mul;
    assign mul = a * b;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod    <= '0;
            p_valid <= 1'b0;
            p_first <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= en;
            if (en) begin
                prod    <= {{(ACC_W-2*DATA_W){mul[2*DATA_W-1]}}, mul};
                p_first <= first;
                p_last  <= last;
            end
        end
    end
endmodule

// File: rtl/mat_dot_product_unit.sv
// mat_dot_product_unit: streaming signed dot-product engine with valid/ready result handshake
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               synchronous abort of the current vector (drops any pending result)
//   in_valid, in_ready  operand-pair handshake
//   a_in, b_in          signed A-row / B-column elements
//   out_valid, out_ready result handshake
//   out_data            signed dot-product result
//   busy                a vector is in progress or a result is pending
module mat_dot_product_unit
    import mat_dot_product_unit_pkg::*;
#(
    parameter int DATA_W  = DP_DATA_W,
    parameter int VEC_LEN = DP_VEC_LEN,
    parameter int CNT_W   = $clog2(VEC_LEN),
    parameter int ACC_W   = 2 * DATA_W + CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    dp_state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic accept, is_last;
    logic p_valid, p_first, p_last;
    logic signed [ACC_W-1:0] prod, acc, sum;

    mat_mult_stage #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (accept),
        .first   (cnt == '0),
        .last    (is_last),
        .a       (a_in),
        .b       (b_in),
        .prod    (prod),
        .p_valid (p_valid),
        .p_first (p_first),
        .p_last  (p_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = rst_n && !clear && state == ACCUM;
        out_valid = state == HOLD;
        busy      = state != ACCUM || cnt != '0;
        accept    = in_valid && in_ready;
        is_last   = cnt == LAST;
        // p_first re-seeds the accumulator so a cleared vector never leaks into the next one
        sum       = p_first ? prod : acc + prod;
        case (state)
            ACCUM:   state_n = (accept && is_last) ? FLUSH : ACCUM;
            FLUSH:   state_n = HOLD;
            HOLD:    state_n = out_ready ? ACCUM : HOLD;
            default: state_n = ACCUM;
        endcase
        if (clear) state_n = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (clear)       cnt <= '0;
            else if (accept) cnt <= is_last ? '0 : cnt + 1'b1;
            if (p_valid) acc <= sum;
            // the last product is still in flight during FLUSH, so fold it in directly
            if (state == FLUSH && p_valid && p_last && !clear) out_data <= sum;
        end
    end
endmodule
